// File: rtl/neural_input_conditioner_pkg.sv
// Purpose: shared constants and helpers for the neural SoC input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package neural_io_pkg;

    localparam int   NUM_KEYS_DEF        = 4;
    localparam int   NUM_SW_DEF          = 8;

    // Electrical idle level of each input family: keys are active-low, so an
    // untouched key reads 1; switches power up in the off (0) position.
    localparam logic KEY_IDLE            = 1'b1;
    localparam logic SW_IDLE             = 1'b0;

    // 10 ms debounce and 1 s long-press at a 50 MHz clock.
    localparam int   DEBOUNCE_CYCLES_DEF = 500000;
    localparam int   HOLD_CYCLES_DEF     = 50000000;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/neural_debounce_bit.sv
// Purpose: two-flop synchroniser plus stability counter for one raw input bit.
// Latency: raw change first sampled at edge E appears on level at edge E+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running level output with next-edge change strobes.
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   raw_in  asynchronous raw input bit
//   level   debounced level (registered)
//   rise    combinational strobe: level goes 0->1 on the coming edge
//   fall    combinational strobe: level goes 1->0 on the coming edge
module neural_debounce_bit
    import neural_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic IDLE            = SW_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             accept;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sync2_q == level_q) begin
            // Any sample agreeing with the current level restarts the count,
            // which is what swallows bounces shorter than the window.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            level_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

    // Strobes are exposed unregistered so the parent can register its pulses
    // and clear hold state on the very edge the level changes. Masked in reset
    // so no pulse can be captured on a reset edge.
    assign rise = accept & sync2_q  & ~rst;
    assign fall = accept & ~sync2_q & ~rst;

endmodule

// File: rtl/neural_input_conditioner.sv
// Purpose: debounce board keys/switches and derive press/release/change pulses and long-press hold.
// Latency: level and pulses update DEBOUNCE_CYCLES+1 edges after a clean raw change is first sampled.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
//
// Ports:
//   clk_clk      system clock (SoC domain)
//   reset_reset  synchronous active-high reset
//   key_raw_n    raw active-low pushbuttons (async)
//   sw_raw       raw slide switches (async)
//   key_level    debounced keys, active-low (to key_wire_export)
//   key_press    1-cycle pulse per key on debounced 1->0
//   key_release  1-cycle pulse per key on debounced 0->1
//   key_hold     high while a key has been pressed >= HOLD_CYCLES
//   sw_level     debounced switches (to switch_wire_export)
//   sw_change    1-cycle pulse when any sw_level bit changes
module neural_input_conditioner
    import neural_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int NUM_SW          = NUM_SW_DEF
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_hold,
    output logic [NUM_SW-1:0]   sw_level,
    output logic                sw_change
);

    localparam int                HCNT_W   = clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_CYCLES);

    logic [NUM_KEYS-1:0] key_rise, key_fall;
    logic [NUM_SW-1:0]   sw_rise,  sw_fall;

    logic [HCNT_W-1:0]   hcnt_q [NUM_KEYS];
    logic [HCNT_W-1:0]   hcnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_hold_q,    key_hold_d;
    logic [NUM_KEYS-1:0] key_press_q,   key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic                sw_change_q,   sw_change_d;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        neural_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (KEY_IDLE)
        ) u_db (
            .clk    (clk_clk),
            .rst    (reset_reset),
            .raw_in (key_raw_n[gi]),
            .level  (key_level[gi]),
            .rise   (key_rise[gi]),
            .fall   (key_fall[gi])
        );
    end

    for (genvar gs = 0; gs < NUM_SW; gs++) begin : g_sw
        neural_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (SW_IDLE)
        ) u_db (
            .clk    (clk_clk),
            .rst    (reset_reset),
            .raw_in (sw_raw[gs]),
            .level  (sw_level[gs]),
            .rise   (sw_rise[gs]),
            .fall   (sw_fall[gs])
        );
    end

    always_comb begin
        // Keys are active-low: a debounced fall is a press, a rise a release.
        key_press_d   = key_fall;
        key_release_d = key_rise;
        // Bits accepted on the same edge merge into one pulse.
        sw_change_d   = |(sw_rise | sw_fall);
        key_hold_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hcnt_d[i] = hcnt_q[i];
            if (key_rise[i]) begin
                // Release clears on the same edge as key_release.
                hcnt_d[i] = '0;
            end else if (!key_level[i] && (hcnt_q[i] < HOLD_MAX)) begin
                // key_level is still 1 on the press edge itself, so counting
                // starts the edge after; hold lands HOLD_CYCLES edges after press.
                hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
            key_hold_d[i] = (hcnt_d[i] == HOLD_MAX);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                hcnt_q[i] <= '0;
            end
            key_hold_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            sw_change_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
            key_hold_q    <= key_hold_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            sw_change_q   <= sw_change_d;
        end
    end

    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_hold    = key_hold_q;
    assign sw_change   = sw_change_q;

endmodule

// File: tb/tb_neural_input_conditioner.sv
// Purpose: scoreboard bench for neural_input_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10).
// Latency: expectations are scheduled at absolute edge numbers when stimulus is driven.
// Backpressure: n/a.
module tb_neural_input_conditioner;

    localparam int DB = 4;
    localparam int HC = 10;

    localparam int F_KL = 0;
    localparam int F_KP = 1;
    localparam int F_KR = 2;
    localparam int F_KH = 3;
    localparam int F_SL = 4;
    localparam int F_SC = 5;

    logic       clk_clk;
    logic       reset_reset;
    logic [3:0] key_raw_n;
    logic [7:0] sw_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_hold;
    logic [7:0] sw_level;
    logic       sw_change;

    neural_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .NUM_KEYS        (4),
        .NUM_SW          (8)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .key_raw_n   (key_raw_n),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_hold    (key_hold),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // An event says: from edge 'at' onward, output field 'fld' reads 'val'.
    typedef struct {
        int         at;
        int         fld;
        logic [7:0] val;
    } sb_ev_t;

    sb_ev_t     sb_q[$];
    logic [7:0] shadow [6];
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       mon_en   = 1'b0;

    always @(posedge clk_clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h want %h", tag, edge_cnt, act, exp);
        end
    endtask

    task automatic sb_push(input int at, input int fld, input logic [7:0] val);
        sb_ev_t ev;
        ev.at  = at;
        ev.fld = fld;
        ev.val = val;
        sb_q.push_back(ev);
    endtask

    // A pulse is high for exactly one edge.
    task automatic sb_pulse(input int at, input int fld, input logic [7:0] val);
        sb_push(at, fld, val);
        sb_push(at + 1, fld, 8'h00);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // Monitor: apply due scoreboard events, then compare every output.
    always @(negedge clk_clk) begin
        if (mon_en) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].at == edge_cnt) begin
                    shadow[sb_q[i].fld] = sb_q[i].val;
                    sb_q.delete(i);
                end
            end
            check_eq("key_level",   {4'h0, key_level},   shadow[F_KL]);
            check_eq("key_press",   {4'h0, key_press},   shadow[F_KP]);
            check_eq("key_release", {4'h0, key_release}, shadow[F_KR]);
            check_eq("key_hold",    {4'h0, key_hold},    shadow[F_KH]);
            check_eq("sw_level",    sw_level,            shadow[F_SL]);
            check_eq("sw_change",   {7'h0, sw_change},   shadow[F_SC]);
        end
    end

    initial begin
        int t;
        shadow[F_KL] = 8'h0F;
        shadow[F_KP] = 8'h00;
        shadow[F_KR] = 8'h00;
        shadow[F_KH] = 8'h00;
        shadow[F_SL] = 8'h00;
        shadow[F_SC] = 8'h00;

        // Reset and idle.
        reset_reset = 1'b1;
        key_raw_n   = 4'hF;
        sw_raw      = 8'h00;
        step(3);
        reset_reset = 1'b0;
        mon_en      = 1'b1;
        step(20);

        // Key 0 press: level and press at E+5 (E = t+1), hold 10 edges later.
        key_raw_n = 4'hE;
        t = edge_cnt;
        sb_push (t + 6,  F_KL, 8'h0E);
        sb_pulse(t + 6,  F_KP, 8'h01);
        sb_push (t + 16, F_KH, 8'h01);
        step(25);

        // Key 0 release: release pulse and hold drop on the same edge.
        key_raw_n = 4'hF;
        t = edge_cnt;
        sb_push (t + 6, F_KL, 8'h0F);
        sb_pulse(t + 6, F_KR, 8'h01);
        sb_push (t + 6, F_KH, 8'h00);
        step(10);

        // Key 1 bounce: low 3 / high 1, never long enough to be accepted.
        for (int r = 0; r < 5; r++) begin
            key_raw_n[1] = 1'b0;
            step(3);
            key_raw_n[1] = 1'b1;
            step(1);
        end
        key_raw_n[1] = 1'b0;
        t = edge_cnt;
        sb_push (t + 6,  F_KL, 8'h0D);
        sb_pulse(t + 6,  F_KP, 8'h02);
        sb_push (t + 16, F_KH, 8'h02);
        step(20);
        key_raw_n[1] = 1'b1;
        t = edge_cnt;
        sb_push (t + 6, F_KL, 8'h0F);
        sb_pulse(t + 6, F_KR, 8'h02);
        sb_push (t + 6, F_KH, 8'h00);
        step(10);

        // Switches: multi-bit change in one cycle gives one pulse.
        sw_raw = 8'hA5;
        t = edge_cnt;
        sb_push (t + 6, F_SL, 8'hA5);
        sb_pulse(t + 6, F_SC, 8'h01);
        step(10);

        // Bit 0 then bit 7 two cycles later: two separate pulses.
        sw_raw = 8'hA4;
        t = edge_cnt;
        sb_push (t + 6, F_SL, 8'hA4);
        sb_pulse(t + 6, F_SC, 8'h01);
        step(2);
        sw_raw = 8'h24;
        sb_push (t + 8, F_SL, 8'h24);
        sb_pulse(t + 8, F_SC, 8'h01);
        step(12);

        // Reset while key 2 is mid-count; everything restarts, switches
        // are re-accepted from their reset value of 0.
        key_raw_n[2] = 1'b0;
        t = edge_cnt;
        sb_push (t + 5,  F_SL, 8'h00);
        sb_push (t + 11, F_KL, 8'h0B);
        sb_pulse(t + 11, F_KP, 8'h04);
        sb_push (t + 11, F_SL, 8'h24);
        sb_pulse(t + 11, F_SC, 8'h01);
        sb_push (t + 21, F_KH, 8'h04);
        step(4);
        reset_reset = 1'b1;
        step(1);
        reset_reset = 1'b0;
        step(25);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
